axis_pkt_gen: RTL and testbench

AXI4-Stream packet generator that drives the slave stream input (s_axis_tdata/tkeep/tvalid/tlast) of the DUTs in our benches and FPGA loopback builds. Software or a bench task loads length, count, gap and seed, then pulses start. The block emits a deterministic, self-checkable packet train and honours tready backpressure.

---
 rtl/axis_pkt_gen_pkg.sv | 15 +
 rtl/axis_pkt_gen_if.sv | 17 +
 rtl/prbs31_gen.sv | 52 +++++
 rtl/axis_pkt_gen.sv | 226 ++++++++++++++++++++++
 tb/tb_axis_pkt_gen.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkt_gen_pkg.sv
// Shared types and constants for the AXI4-Stream packet generator.
//   state_e      : generator FSM state encoding
//   PRBS31_TAPS  : feedback taps of x^31 + x^28 + 1 over a 31-bit shift state
package axis_pkt_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Bits 30 and 27 of the shift state feed back (x^31 and x^28 terms).
  localparam logic [30:0] PRBS31_TAPS = 31'h4800_0000;

endpackage

// File: rtl/axis_pkt_gen_if.sv
// AXI4-Stream bundle driven by the packet generator.
//   tdata/tkeep/tvalid/tlast : master -> slave
//   tready                   : slave -> master
interface axis_pkt_gen_if #(
  parameter int unsigned DATA_WIDTH = 64
);
  localparam int unsigned BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] tdata;
  logic [BYTES-1:0]      tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/prbs31_gen.sv
// PRBS-31 word generator (x^31 + x^28 + 1), DATA_WIDTH bits per step.
//   clk, rst : clock, synchronous active-high reset
//   load     : reseed from seed (0 replaced by 1); data reflects the new seed
//   seed     : 32-bit seed, only the low 31 bits form the state
//   advance  : consume the current word
//   data     : word produced from the current (or loading) state, bit 0 first
module prbs31_gen
  import axis_pkt_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [31:0]           seed,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] data
);

  logic [30:0] state_q;
  logic [30:0] cur_c;
  logic [30:0] nxt_c;
  logic        fb_c;
  logic        unused_seed_msb;

  assign unused_seed_msb = seed[31];

  // Word for the current state and the state after emitting it.
  always_comb begin
    fb_c  = 1'b0;
    cur_c = state_q;
    if (load) begin
      cur_c = (seed[30:0] == '0) ? 31'd1 : seed[30:0];
    end
    nxt_c = cur_c;
    data  = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      fb_c    = ^(nxt_c & PRBS31_TAPS);
      data[i] = fb_c;
      nxt_c   = {nxt_c[29:0], fb_c};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= 31'd1;
    end else if (load || advance) begin
      state_q <= nxt_c;
    end
  end

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet generator: emits pkt_num packets of pkt_len bytes with
// gap idle cycles between them, honouring tready backpressure.
//   clk, rst           : clock, synchronous active-high reset
//   start, stop        : run request (config latched) / graceful abort
//   pkt_len/num, gap   : run configuration; seed for the PRBS payload
//   busy, done, cfg_err: run status; pkt_sent counts completed packets
//   m_axis             : stream master (axis_pkt_gen_if.master)
// Build option AXIS_PKT_GEN_PRBS_EN: PRBS-31 payload instead of the
// {packet index, beat index} counter pattern.
module axis_pkt_gen
  import axis_pkt_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned GAP_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [LEN_WIDTH-1:0] pkt_len,
  input  logic [CNT_WIDTH-1:0] pkt_num,
  input  logic [GAP_WIDTH-1:0] gap,
  input  logic [31:0]          seed,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic [CNT_WIDTH-1:0] pkt_sent,
  axis_pkt_gen_if.master       m_axis
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned BSH   = $clog2(BYTES);
  localparam int unsigned HALF  = DATA_WIDTH / 2;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d, beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d, sent_q, sent_d;
  logic [GAP_WIDTH-1:0]  gap_q, gap_d, gcnt_q, gcnt_d;
  logic                  stop_q, stop_d, busy_q, busy_d;
  logic                  done_q, done_d, err_q, err_d;
  logic                  valid_q, valid_d, last_q, last_d;
  logic [BYTES-1:0]      keep_q, keep_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // Beat to be presented on the next cycle, when present_c is set.
  logic                  present_c, load_c, adv_c, accept_c;
  logic [LEN_WIDTH-1:0]  pres_len_c, pres_beat_c, last_idx_c;
  logic [CNT_WIDTH-1:0]  pres_pkt_c;
  logic [BSH-1:0]        rem_c;
  logic [DATA_WIDTH-1:0] word_c;

  assign accept_c = valid_q & m_axis.tready;
  assign adv_c    = present_c & ~load_c;

`ifdef AXIS_PKT_GEN_PRBS_EN
  logic unused_cnt;
  assign unused_cnt = ^pres_pkt_c;

  prbs31_gen #(.DATA_WIDTH(DATA_WIDTH)) u_prbs (
    .clk     (clk),
    .rst     (rst),
    .load    (load_c),
    .seed    (seed),
    .advance (adv_c),
    .data    (word_c)
  );
`else
  logic unused_prbs;
  assign unused_prbs = ^{seed, load_c, adv_c};
  assign word_c = {HALF'(pres_pkt_c), HALF'(pres_beat_c)};
`endif

  // Next-state and run control.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    num_d       = num_q;
    gap_d       = gap_q;
    gcnt_d      = gcnt_q;
    beat_d      = beat_q;
    sent_d      = sent_q;
    stop_d      = stop_q;
    busy_d      = busy_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    present_c   = 1'b0;
    load_c      = 1'b0;
    pres_len_c  = len_q;
    pres_pkt_c  = sent_q;
    pres_beat_c = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (pkt_len == '0 || pkt_num == '0) begin
            err_d = 1'b1;
          end else begin
            state_d    = SEND;
            len_d      = pkt_len;
            num_d      = pkt_num;
            gap_d      = gap;
            sent_d     = '0;
            beat_d     = '0;
            stop_d     = 1'b0;
            busy_d     = 1'b1;
            valid_d    = 1'b1;
            present_c  = 1'b1;
            load_c     = 1'b1;
            pres_len_c = pkt_len;
            pres_pkt_c = '0;
          end
        end
      end
      SEND: begin
        if (stop) stop_d = 1'b1;
        if (accept_c) begin
          if (last_q) begin
            sent_d = sent_q + CNT_WIDTH'(1);
            if (sent_d == num_q || stop_d) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              valid_d = 1'b0;
              state_d = IDLE;
            end else if (gap_q == '0) begin
              beat_d     = '0;
              present_c  = 1'b1;
              pres_pkt_c = sent_d;
            end else begin
              valid_d = 1'b0;
              gcnt_d  = gap_q;
              state_d = GAP;
            end
          end else begin
            beat_d      = beat_q + LEN_WIDTH'(1);
            present_c   = 1'b1;
            pres_beat_c = beat_d;
          end
        end
      end
      GAP: begin
        if (stop) begin
          stop_d  = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (gcnt_q == GAP_WIDTH'(1)) begin
          state_d   = SEND;
          valid_d   = 1'b1;
          beat_d    = '0;
          present_c = 1'b1;
        end else begin
          gcnt_d = gcnt_q - GAP_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat formatting: tlast on the final beat, partial tkeep, masked bytes.
  always_comb begin
    last_idx_c = (pres_len_c - LEN_WIDTH'(1)) >> BSH;
    rem_c      = pres_len_c[BSH-1:0];
    last_d     = last_q;
    keep_d     = keep_q;
    data_d     = data_q;
    if (present_c) begin
      last_d = (pres_beat_c == last_idx_c);
      for (int i = 0; i < int'(BYTES); i++) begin
        keep_d[i]       = !last_d || (rem_c == '0) || (BSH'(i) < rem_c);
        data_d[i*8 +: 8] = keep_d[i] ? word_c[i*8 +: 8] : 8'h00;
      end
    end else if (!valid_d) begin
      last_d = 1'b0;
      keep_d = '0;
      data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      num_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      beat_q  <= '0;
      sent_q  <= '0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      keep_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      num_q   <= num_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      beat_q  <= beat_d;
      sent_q  <= sent_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      keep_q  <= keep_d;
      data_q  <= data_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign cfg_err       = err_q;
  assign pkt_sent      = sent_q;
  assign m_axis.tdata  = data_q;
  assign m_axis.tkeep  = keep_q;
  assign m_axis.tvalid = valid_q;
  assign m_axis.tlast  = last_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed bench for axis_pkt_gen (counter payload build).
module tb_axis_pkt_gen;

  localparam int unsigned DW = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [15:0] pkt_len;
  logic [15:0] pkt_num;
  logic [7:0]  gap;
  logic [31:0] seed;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic [15:0] pkt_sent;

  axis_pkt_gen_if #(.DATA_WIDTH(DW)) m_axis ();

  axis_pkt_gen #(
    .DATA_WIDTH(DW), .LEN_WIDTH(16), .CNT_WIDTH(16), .GAP_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .pkt_len  (pkt_len),
    .pkt_num  (pkt_num),
    .gap      (gap),
    .seed     (seed),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err),
    .pkt_sent (pkt_sent),
    .m_axis   (m_axis)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cur_vec = -1;

  typedef struct {
    int len;
    int num;
    int gap;
    bit rnd;
    int stop_at;    // accepted-beat count at which stop pulses, -1 = never
    int exp_beats;
    int exp_sent;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", cur_vec, name, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_keep(input int len, input int bt);
    int nb  = (len + 7) / 8;
    int rem = len % 8;
    if (bt == nb - 1 && rem != 0) return 8'((1 << rem) - 1);
    return 8'hFF;
  endfunction

  function automatic logic [63:0] exp_data(input int pk, input int bt, input int len);
    logic [63:0] d = {32'(pk), 32'(bt)};
    logic [7:0]  k = exp_keep(len, bt);
    for (int i = 0; i < 8; i++) if (!k[i]) d[i*8 +: 8] = 8'h00;
    return d;
  endfunction

  task automatic run_vec(input vec_t v);
    int pk = 0, bt = 0, beats = 0, cycles = 0, lowrun = 0, last_acc = -10, nb;
    bit stalled = 0, stop_done = 0, rdy;
    logic [63:0] hd;
    logic [7:0]  hk;
    logic        hl;
    nb = (v.len + 7) / 8;
    pkt_len = 16'(v.len); pkt_num = 16'(v.num); gap = 8'(v.gap);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("latency_tvalid", 64'(m_axis.tvalid), 64'd1);
    chk("latency_busy", 64'(busy), 64'd1);
    while (!done && cycles < 2000) begin
      stop = (v.stop_at >= 0 && beats == v.stop_at && !stop_done);
      if (stop) stop_done = 1;
      if (m_axis.tvalid) begin
        if (stalled) begin
          chk("hold_tdata", m_axis.tdata, hd);
          chk("hold_tkeep", 64'(m_axis.tkeep), 64'(hk));
          chk("hold_tlast", 64'(m_axis.tlast), 64'(hl));
        end else if (bt == 0 && pk > 0) begin
          chk("gap_cycles", 64'(lowrun), 64'(v.gap));
        end
        lowrun = 0;
        rdy = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        m_axis.tready = rdy;
        if (rdy) begin
          chk("beat_tdata", m_axis.tdata, exp_data(pk, bt, v.len));
          chk("beat_tkeep", 64'(m_axis.tkeep), 64'(exp_keep(v.len, bt)));
          chk("beat_tlast", 64'(m_axis.tlast), 64'(bt == nb - 1));
          beats++;
          last_acc = cycles;
          stalled = 0;
          if (bt == nb - 1) begin bt = 0; pk++; end
          else bt++;
        end else begin
          stalled = 1;
          hd = m_axis.tdata; hk = m_axis.tkeep; hl = m_axis.tlast;
        end
      end else begin
        lowrun++;
        m_axis.tready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
      cycles++;
    end
    stop = 1'b0;
    m_axis.tready = 1'b1;
    chk("done_seen", 64'(done), 64'd1);
    chk("done_after_last", 64'(cycles - last_acc), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_tvalid", 64'(m_axis.tvalid), 64'd0);
    chk("pkt_sent", 64'(pkt_sent), 64'(v.exp_sent));
    chk("beat_count", 64'(beats), 64'(v.exp_beats));
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_cfg_err"}, 64'(cfg_err), 64'd0);
    chk({tag, "_tvalid"}, 64'(m_axis.tvalid), 64'd0);
    chk({tag, "_tlast"}, 64'(m_axis.tlast), 64'd0);
    chk({tag, "_tkeep"}, 64'(m_axis.tkeep), 64'd0);
    chk({tag, "_tdata"}, m_axis.tdata, 64'd0);
    chk({tag, "_pkt_sent"}, 64'(pkt_sent), 64'd0);
  endtask

  initial begin
    //             len num gap rnd stop beats sent
    vecs[0] = '{64, 2, 0, 1'b0, -1, 16, 2};
    vecs[1] = '{13, 1, 0, 1'b0, -1,  2, 1};
    vecs[2] = '{ 8, 3, 4, 1'b0, -1,  3, 3};
    vecs[3] = '{64, 2, 0, 1'b1, -1, 16, 2};
    vecs[4] = '{13, 3, 2, 1'b1, -1,  6, 3};
    vecs[5] = '{ 8, 1, 0, 1'b0, -1,  1, 1};
    vecs[6] = '{16, 5, 0, 1'b0,  2,  4, 2};

    rst = 1'b1; start = 1'b0; stop = 1'b0;
    pkt_len = '0; pkt_num = '0; gap = '0; seed = 32'h1234_5678;
    m_axis.tready = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      cur_vec = i;
      run_vec(vecs[i]);
    end
    cur_vec = 100;

    // Rejected starts: zero length, then zero count.
    pkt_len = 16'd0; pkt_num = 16'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("len0_cfg_err", 64'(cfg_err), 64'd1);
    chk("len0_busy", 64'(busy), 64'd0);
    chk("len0_tvalid", 64'(m_axis.tvalid), 64'd0);
    @(negedge clk);
    chk("len0_err_pulse", 64'(cfg_err), 64'd0);
    pkt_len = 16'd8; pkt_num = 16'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("num0_cfg_err", 64'(cfg_err), 64'd1);
    chk("num0_busy", 64'(busy), 64'd0);
    @(negedge clk);

    // stop in IDLE has no effect.
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("idle_stop_busy", 64'(busy), 64'd0);
    chk("idle_stop_done", 64'(done), 64'd0);

    // Start accepted in the done cycle of the previous run.
    cur_vec = 101;
    pkt_len = 16'd8; pkt_num = 16'd1; gap = 8'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("b2b_first_tlast", 64'(m_axis.tlast), 64'd1);
    @(negedge clk);
    chk("b2b_done", 64'(done), 64'd1);
    pkt_len = 16'd16; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("b2b_restart_tvalid", 64'(m_axis.tvalid), 64'd1);
    chk("b2b_restart_busy", 64'(busy), 64'd1);
    chk("b2b_restart_sent", 64'(pkt_sent), 64'd0);
    chk("b2b_restart_tlast", 64'(m_axis.tlast), 64'd0);
    @(negedge clk);
    chk("b2b_beat1_tdata", m_axis.tdata, 64'h0000_0000_0000_0001);
    chk("b2b_beat1_tlast", 64'(m_axis.tlast), 64'd1);
    @(negedge clk);
    chk("b2b_done2", 64'(done), 64'd1);
    chk("b2b_sent", 64'(pkt_sent), 64'd1);

    // start while busy is ignored.
    cur_vec = 102;
    m_axis.tready = 1'b0;
    pkt_len = 16'd16; pkt_num = 16'd1; start = 1'b1;
    @(negedge clk);
    pkt_len = 16'd8;
    @(negedge clk); start = 1'b0;
    chk("busy_start_tlast", 64'(m_axis.tlast), 64'd0);
    chk("busy_start_cfg_err", 64'(cfg_err), 64'd0);
    chk("busy_start_tdata", m_axis.tdata, 64'd0);
    m_axis.tready = 1'b1;
    @(negedge clk);
    chk("busy_start_beat1_tlast", 64'(m_axis.tlast), 64'd1);
    @(negedge clk);
    chk("busy_start_done", 64'(done), 64'd1);

    // stop during GAP ends the run at once.
    cur_vec = 103;
    pkt_len = 16'd8; pkt_num = 16'd5; gap = 8'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("gapstop_tvalid", 64'(m_axis.tvalid), 64'd1);
    @(negedge clk);
    chk("gapstop_in_gap", 64'(m_axis.tvalid), 64'd0);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("gapstop_done", 64'(done), 64'd1);
    chk("gapstop_busy", 64'(busy), 64'd0);
    chk("gapstop_sent", 64'(pkt_sent), 64'd1);
    @(negedge clk);
    chk("gapstop_idle_tvalid", 64'(m_axis.tvalid), 64'd0);

    // Reset in the middle of a stalled packet.
    cur_vec = 104;
    m_axis.tready = 1'b0;
    pkt_len = 16'd64; pkt_num = 16'd2; gap = 8'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("rst_pre_tvalid", 64'(m_axis.tvalid), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    rst = 1'b0;
    m_axis.tready = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
